// File: rtl/out_stream_arbiter.sv
// Packet-level round-robin merge of three AXI-Stream sources onto one registered master.
// Latency: 1 arbitration cycle, then 1 cycle source->m_axis; full throughput within a packet.
// Backpressure: only the granted source sees tready, and only when the output register can accept.
module out_stream_arbiter #(
    parameter int DWIDTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] s_axis_tdata_0,
    input  logic              s_axis_tvalid_0,
    output logic              s_axis_tready_0,
    input  logic              s_axis_tlast_0,
    input  logic [DWIDTH-1:0] s_axis_tdata_1,
    input  logic              s_axis_tvalid_1,
    output logic              s_axis_tready_1,
    input  logic              s_axis_tlast_1,
    input  logic [DWIDTH-1:0] s_axis_tdata_2,
    input  logic              s_axis_tvalid_2,
    output logic              s_axis_tready_2,
    input  logic              s_axis_tlast_2,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [1:0]        grant,
    output logic              busy
);
    typedef enum logic {IDLE, PASS} state_t;

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt, grant_nxt, pick, ptr_p1, ptr_p2;
    logic [3:0]        vld_vec;
    logic [DWIDTH-1:0] data_g, tdata_nxt;
    logic              vld_g, last_g, tvalid_nxt, tlast_nxt, can_accept, hs;

    // bit 3 is padding so a 2-bit index can never select out of range
    assign vld_vec    = {1'b0, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign ptr_p1     = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    assign ptr_p2     = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    assign can_accept = ~m_axis_tvalid | m_axis_tready;

    always_comb begin
        pick = ptr;
        if (vld_vec[ptr])         pick = ptr;
        else if (vld_vec[ptr_p1]) pick = ptr_p1;
        else if (vld_vec[ptr_p2]) pick = ptr_p2;
    end

    always_comb begin
        data_g = '0;
        vld_g  = 1'b0;
        last_g = 1'b0;
        case (grant)
            2'd0: begin data_g = s_axis_tdata_0; vld_g = s_axis_tvalid_0; last_g = s_axis_tlast_0; end
            2'd1: begin data_g = s_axis_tdata_1; vld_g = s_axis_tvalid_1; last_g = s_axis_tlast_1; end
            2'd2: begin data_g = s_axis_tdata_2; vld_g = s_axis_tvalid_2; last_g = s_axis_tlast_2; end
            default: ;
        endcase
    end

    assign s_axis_tready_0 = (state == PASS) && (grant == 2'd0) && can_accept;
    assign s_axis_tready_1 = (state == PASS) && (grant == 2'd1) && can_accept;
    assign s_axis_tready_2 = (state == PASS) && (grant == 2'd2) && can_accept;
    assign hs              = (state == PASS) && vld_g && can_accept;
    assign busy            = (state == PASS) || m_axis_tvalid;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        tdata_nxt  = m_axis_tdata;
        tlast_nxt  = m_axis_tlast;
        tvalid_nxt = m_axis_tvalid;
        case (state)
            IDLE: begin
                if (|vld_vec) begin
                    grant_nxt = pick;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (hs && last_g) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                    grant_nxt = 2'd3;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // output register also drains its last beat while back in IDLE
        if (hs) begin
            tdata_nxt  = data_g;
            tlast_nxt  = last_g;
            tvalid_nxt = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 2'd0;
            grant         <= 2'd3;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            grant         <= grant_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tlast  <= tlast_nxt;
            m_axis_tvalid <= tvalid_nxt;
        end
    end
endmodule

// File: tb/tb_out_stream_arbiter.sv
// Directed bench for out_stream_arbiter: per-source beat queues feed the DUT, outputs checked after each edge.
module tb_out_stream_arbiter;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sd [3];
    logic [2:0]    sv, sl;
    wire  [2:0]    sr;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast, busy;
    logic [1:0]    grant;
    logic [DW:0]   q0[$], q1[$], q2[$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    out_stream_arbiter #(.DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata_0(sd[0]), .s_axis_tvalid_0(sv[0]), .s_axis_tready_0(sr[0]), .s_axis_tlast_0(sl[0]),
        .s_axis_tdata_1(sd[1]), .s_axis_tvalid_1(sv[1]), .s_axis_tready_1(sr[1]), .s_axis_tlast_1(sl[1]),
        .s_axis_tdata_2(sd[2]), .s_axis_tvalid_2(sv[2]), .s_axis_tready_2(sr[2]), .s_axis_tlast_2(sl[2]),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dv(input int s, input int p, input int b);
        dv = {8{16'(16'h1000 + s * 256 + p * 16 + b)}};
    endfunction

    function automatic int qsize(input int s);
        case (s)
            0:       qsize = q0.size();
            1:       qsize = q1.size();
            default: qsize = q2.size();
        endcase
    endfunction

    function automatic logic [DW:0] front(input int s);
        front = '0;
        if (qsize(s) > 0) begin
            case (s)
                0:       front = q0[0];
                1:       front = q1[0];
                default: front = q2[0];
            endcase
        end
    endfunction

    task automatic push(input int s, input logic [DW-1:0] d, input logic l);
        case (s)
            0:       q0.push_back({l, d});
            1:       q1.push_back({l, d});
            default: q2.push_back({l, d});
        endcase
    endtask

    task automatic drive();
        logic [DW:0] f;
        for (int s = 0; s < 3; s++) begin
            f     = front(s);
            sv[s] = (qsize(s) > 0);
            sd[s] = f[DW-1:0];
            sl[s] = f[DW];
        end
    endtask

    // handshakes are sampled before the edge; accepted beats leave their queue afterwards
    task automatic tick();
        logic [2:0] hs;
        hs = rst ? 3'b000 : (sv & sr);
        @(posedge clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        if (hs[2]) void'(q2.pop_front());
        drive();
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        m_tready = 1'b1;
        drive();
        tick();
        tick();
        chk_s("rst_vld", int'(m_tvalid), 0);
        chk("rst_data", m_tdata, '0);
        chk_s("rst_last", int'(m_tlast), 0);
        chk_s("rst_rdy", int'(sr), 0);
        chk_s("rst_grant", int'(grant), 3);
        chk_s("rst_busy", int'(busy), 0);
        chk_s("rst_ptr", int'(dut.ptr), 0);
        rst = 1'b0;

        // basic pass-through on source 1
        for (int i = 1; i <= 4; i++) push(1, DW'(i), i == 4);
        drive();
        tick();
        chk_s("bas_grant", int'(grant), 1);
        chk_s("bas_vld0", int'(m_tvalid), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("bas_data", m_tdata, DW'(i));
            chk_s("bas_vld", int'(m_tvalid), 1);
            chk_s("bas_last", int'(m_tlast), int'(i == 4));
        end
        chk_s("bas_grant_end", int'(grant), 3);
        chk_s("bas_busy_drain", int'(busy), 1);
        tick();
        chk_s("bas_vld_end", int'(m_tvalid), 0);
        chk_s("bas_busy_end", int'(busy), 0);

        // round robin, all sources continuously loaded with two 2-beat packets
        rst_pulse();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 3; s++) begin
                push(s, dv(s, p, 0), 1'b0);
                push(s, dv(s, p, 1), 1'b1);
            end
        drive();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_s("rr_grant", int'(grant), k % 3);
            chk_s("rr_gap_vld", int'(m_tvalid), 0);
            chk_s("rr_rdy", int'(sr), 1 << (k % 3));
            tick();
            chk("rr_b0", m_tdata, dv(k % 3, k / 3, 0));
            chk_s("rr_b0_last", int'(m_tlast), 0);
            tick();
            chk("rr_b1", m_tdata, dv(k % 3, k / 3, 1));
            chk_s("rr_b1_last", int'(m_tlast), 1);
            chk_s("rr_grant_idle", int'(grant), 3);
        end
        tick();
        chk_s("rr_vld_end", int'(m_tvalid), 0);

        // backpressure on a 3-beat packet from source 0 (ptr is 0 here)
        for (int b = 0; b < 3; b++) push(0, dv(0, 4, b), b == 2);
        drive();
        tick();
        chk_s("bp_grant", int'(grant), 0);
        tick();
        chk("bp_first", m_tdata, dv(0, 4, 0));
        m_tready = 1'b0;
        #1;
        chk_s("bp_rdy_stall0", int'(sr), 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_data", m_tdata, dv(0, 4, 0));
            chk_s("bp_hold_vld", int'(m_tvalid), 1);
            chk_s("bp_hold_rdy", int'(sr), 0);
        end
        m_tready = 1'b1;
        #1;
        chk_s("bp_rdy_resume", int'(sr), 1);
        for (int b = 1; b < 3; b++) begin
            tick();
            chk("bp_data", m_tdata, dv(0, 4, b));
            chk_s("bp_last", int'(m_tlast), int'(b == 2));
        end
        tick();
        chk_s("bp_vld_end", int'(m_tvalid), 0);

        // grant lock: source 2 mid-packet while source 0 requests (ptr is 1 here)
        for (int b = 0; b < 4; b++) push(2, dv(2, 5, b), b == 3);
        drive();
        tick();
        chk_s("lk_grant", int'(grant), 2);
        tick();
        chk("lk_b0", m_tdata, dv(2, 5, 0));
        push(0, dv(0, 6, 0), 1'b1);
        drive();
        for (int b = 1; b < 4; b++) begin
            tick();
            chk("lk_data", m_tdata, dv(2, 5, b));
            chk_s("lk_rdy0", int'(sr[0]), 0);
        end
        chk_s("lk_grant_idle", int'(grant), 3);
        tick();
        chk_s("lk_next_grant", int'(grant), 0);
        chk_s("lk_gap_vld", int'(m_tvalid), 0);
        tick();
        chk("lk_src0_data", m_tdata, dv(0, 6, 0));
        chk_s("lk_src0_last", int'(m_tlast), 1);
        tick();
        chk_s("lk_vld_end", int'(m_tvalid), 0);

        // single-beat packets from sources 0 and 1
        rst_pulse();
        push(0, dv(0, 7, 0), 1'b1);
        push(1, dv(1, 7, 0), 1'b1);
        drive();
        tick();
        chk_s("sb_grant0", int'(grant), 0);
        tick();
        chk("sb_data0", m_tdata, dv(0, 7, 0));
        chk_s("sb_last0", int'(m_tlast), 1);
        chk_s("sb_vld0", int'(m_tvalid), 1);
        tick();
        chk_s("sb_grant1", int'(grant), 1);
        chk_s("sb_gap_vld", int'(m_tvalid), 0);
        tick();
        chk("sb_data1", m_tdata, dv(1, 7, 0));
        chk_s("sb_last1", int'(m_tlast), 1);
        tick();
        chk_s("sb_vld_end", int'(m_tvalid), 0);

        // reset during a 4-beat packet from source 1 (ptr is 2 here)
        for (int b = 0; b < 4; b++) push(1, dv(1, 8, b), b == 3);
        drive();
        tick();
        chk_s("mr_grant", int'(grant), 1);
        tick();
        chk("mr_b0", m_tdata, dv(1, 8, 0));
        tick();
        chk("mr_b1", m_tdata, dv(1, 8, 1));
        rst = 1'b1;
        tick();
        chk_s("mr_vld", int'(m_tvalid), 0);
        chk_s("mr_rdy", int'(sr), 0);
        chk_s("mr_grant_rst", int'(grant), 3);
        chk_s("mr_ptr", int'(dut.ptr), 0);
        chk_s("mr_busy", int'(busy), 0);
        rst = 1'b0;
        q1.delete();
        push(1, dv(1, 9, 0), 1'b0);
        push(1, dv(1, 9, 1), 1'b1);
        drive();
        tick();
        chk_s("mr_new_grant", int'(grant), 1);
        tick();
        chk("mr_new_b0", m_tdata, dv(1, 9, 0));
        chk_s("mr_new_last0", int'(m_tlast), 0);
        tick();
        chk("mr_new_b1", m_tdata, dv(1, 9, 1));
        chk_s("mr_new_last1", int'(m_tlast), 1);
        tick();
        chk_s("mr_vld_end", int'(m_tvalid), 0);
        chk_s("mr_grant_end", int'(grant), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
